// File: rtl/sample_capture_if.sv
// Signal bundle between the sample-capture core and its environment:
// ADC stream, trigger setup, re-arm control, display read port and status.
interface sample_capture_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   // There is no valid/ready pair here. sample_clk is a sys_clk-synchronous
   // level whose rising edge qualifies adc_data for one cycle. rearm is a
   // one-cycle pulse that is always accepted. rd_addr -> rd_data has a fixed
   // one-cycle latency with no flow control.
   logic              sample_clk;
   logic [DATA_W-1:0] adc_data;
   logic [DATA_W-1:0] trig_level;
   logic              trig_slope;
   logic              auto_mode;
   logic              rearm;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              frame_ready;
   logic              busy;
   logic [1:0]        state_dbg;

   modport master (
      output sample_clk, adc_data, trig_level, trig_slope, auto_mode, rearm, rd_addr,
      input  rd_data, frame_ready, busy, state_dbg
   );

   modport slave (
      input  sample_clk, adc_data, trig_level, trig_slope, auto_mode, rearm, rd_addr,
      output rd_data, frame_ready, busy, state_dbg
   );
endinterface

// File: rtl/sample_capture.sv
// Triggered single-frame capture of an ADC stream, strobed by the rising edge of
// the divided sample clock. The frame is held for the display reader until rearm.
module sample_capture #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   sample_capture_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   // DEPTH equals 2**ADDR_W, so the last address is all-ones.
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic              sclk_q;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic              prev_valid_q, prev_valid_d;
   logic [ADDR_W-1:0] auto_cnt_q, auto_cnt_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              frame_ready_q, frame_ready_d;
   logic              busy_q, busy_d;

   logic              tick;
   logic              trig_hit;
   logic              auto_hit;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;

   logic [DATA_W-1:0] mem [DEPTH];

   assign tick = bus.sample_clk & ~sclk_q;

   always_comb begin
      trig_hit = 1'b0;
      if (prev_valid_q) begin
         if (bus.trig_slope)
            trig_hit = (prev_q > bus.trig_level) && (bus.adc_data <= bus.trig_level);
         else
            trig_hit = (prev_q < bus.trig_level) && (bus.adc_data >= bus.trig_level);
      end
   end

   assign auto_hit = bus.auto_mode && (auto_cnt_q == LAST);

   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      auto_cnt_d   = auto_cnt_q;
      wr_addr_d    = wr_addr_q;
      mem_we       = 1'b0;
      mem_waddr    = wr_addr_q;

      case (state_q)
         IDLE: begin
            state_d = ARMED;
         end
         ARMED: begin
            if (tick) begin
               prev_d       = bus.adc_data;
               prev_valid_d = 1'b1;
               if (auto_cnt_q != LAST)
                  auto_cnt_d = auto_cnt_q + 1'b1;
               if (trig_hit || auto_hit) begin
                  mem_we    = 1'b1;
                  mem_waddr = '0;
                  wr_addr_d = ADDR_W'(1);
                  state_d   = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            if (tick) begin
               mem_we    = 1'b1;
               wr_addr_d = wr_addr_q + 1'b1;
               if (wr_addr_q == LAST)
                  state_d = HOLD;
            end
         end
         HOLD: begin
            state_d = HOLD;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // rearm overrides any tick in the same cycle, including the prev load.
      if (bus.rearm && (state_q != IDLE)) begin
         state_d      = ARMED;
         prev_d       = prev_q;
         prev_valid_d = 1'b0;
         auto_cnt_d   = '0;
         wr_addr_d    = '0;
         mem_we       = 1'b0;
      end

      frame_ready_d = (state_d == HOLD);
      busy_d        = (state_d == ARMED) || (state_d == CAPTURE);
      rd_data_d     = mem[bus.rd_addr];
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sclk_q        <= 1'b0;
         prev_q        <= '0;
         prev_valid_q  <= 1'b0;
         auto_cnt_q    <= '0;
         wr_addr_q     <= '0;
         rd_data_q     <= '0;
         frame_ready_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sclk_q        <= bus.sample_clk;
         prev_q        <= prev_d;
         prev_valid_q  <= prev_valid_d;
         auto_cnt_q    <= auto_cnt_d;
         wr_addr_q     <= wr_addr_d;
         rd_data_q     <= rd_data_d;
         frame_ready_q <= frame_ready_d;
         busy_q        <= busy_d;
      end
   end

   // Frame buffer contents survive reset.
   always_ff @(posedge sys_clk) begin
      if (mem_we)
         mem[mem_waddr] <= bus.adc_data;
   end

   assign bus.rd_data     = rd_data_q;
   assign bus.frame_ready = frame_ready_q;
   assign bus.busy        = busy_q;
   assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture: trigger slopes, first-tick suppression,
// auto mode, rearm abort/collision and asynchronous reset.
module tb_sample_capture;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_HOLD    = 2'd3;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [DATA_W-1:0] exp_q[$];

   sample_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   sample_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .sys_clk (clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick(input logic [DATA_W-1:0] d);
      @(negedge clk);
      bus.adc_data   = d;
      bus.sample_clk = 1'b1;
      @(negedge clk);
      bus.sample_clk = 1'b0;
   endtask

   task automatic pulse_rearm();
      @(negedge clk);
      bus.rearm = 1'b1;
      @(negedge clk);
      bus.rearm = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] exp);
      exp_q.push_back(exp);
      @(negedge clk);
      bus.rd_addr = addr;
      @(negedge clk);
      chk(tag, 32'(bus.rd_data), 32'(exp_q.pop_front()));
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      rst_n          = 1'b0;
      bus.sample_clk = 1'b0;
      bus.adc_data   = '0;
      bus.trig_level = 8'd128;
      bus.trig_slope = 1'b0;
      bus.auto_mode  = 1'b0;
      bus.rearm      = 1'b0;
      bus.rd_addr    = '0;

      // reset with sample_clk toggling
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.sample_clk = ~bus.sample_clk;
      end
      @(negedge clk);
      bus.sample_clk = 1'b0;
      chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
      chk("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
      rst_n = 1'b1;
      @(negedge clk);
      chk("arm_busy", 32'(bus.busy), 32'd1);
      chk("arm_state", 32'(bus.state_dbg), 32'(S_ARMED));

      // rising trigger on ramp
      tick(8'd100);
      tick(8'd110);
      tick(8'd120);
      chk("rise_pre_state", 32'(bus.state_dbg), 32'(S_ARMED));
      tick(8'd130);
      chk("rise_trig_state", 32'(bus.state_dbg), 32'(S_CAPTURE));
      for (int j = 1; j < 255; j++) tick(8'(130 + 10 * j));
      chk("rise_not_ready", 32'(bus.frame_ready), 32'd0);
      tick(8'(130 + 10 * 255));
      chk("rise_ready", 32'(bus.frame_ready), 32'd1);
      chk("rise_busy", 32'(bus.busy), 32'd0);
      read_chk("rise_rd0", 8'd0, 8'd130);
      read_chk("rise_rd1", 8'd1, 8'd140);
      read_chk("rise_rd255", 8'd255, 8'd120);
      tick(8'd7);
      chk("hold_state", 32'(bus.state_dbg), 32'(S_HOLD));
      read_chk("hold_rd0", 8'd0, 8'd130);

      // falling slope, first tick after arm never triggers (stale prev = 130)
      bus.trig_slope = 1'b1;
      pulse_rearm();
      chk("rearm_ready", 32'(bus.frame_ready), 32'd0);
      chk("rearm_busy", 32'(bus.busy), 32'd1);
      tick(8'd100);
      chk("fall_first_tick", 32'(bus.state_dbg), 32'(S_ARMED));
      tick(8'd200);
      tick(8'd140);
      chk("fall_pre_state", 32'(bus.state_dbg), 32'(S_ARMED));
      tick(8'd100);
      chk("fall_trig_state", 32'(bus.state_dbg), 32'(S_CAPTURE));
      for (int k = 1; k < 256; k++) tick(8'(k));
      chk("fall_ready", 32'(bus.frame_ready), 32'd1);
      read_chk("fall_rd0", 8'd0, 8'd100);
      read_chk("fall_rd200", 8'd200, 8'd200);

      // rearm abort during capture, then rearm colliding with a tick
      bus.trig_slope = 1'b0;
      pulse_rearm();
      tick(8'd100);
      tick(8'd130);
      chk("abort_capture", 32'(bus.state_dbg), 32'(S_CAPTURE));
      for (int k = 1; k < 10; k++) tick(8'(10 + k));
      pulse_rearm();
      chk("abort_state", 32'(bus.state_dbg), 32'(S_ARMED));
      chk("abort_busy", 32'(bus.busy), 32'd1);
      chk("abort_ready", 32'(bus.frame_ready), 32'd0);
      bus.trig_slope = 1'b1;
      @(negedge clk);
      bus.rearm      = 1'b1;
      bus.adc_data   = 8'd200;
      bus.sample_clk = 1'b1;
      @(negedge clk);
      bus.rearm      = 1'b0;
      bus.sample_clk = 1'b0;
      chk("coll_state", 32'(bus.state_dbg), 32'(S_ARMED));
      tick(8'd100);
      chk("coll_no_prev", 32'(bus.state_dbg), 32'(S_ARMED));
      tick(8'd140);
      tick(8'd120);
      chk("coll_trig", 32'(bus.state_dbg), 32'(S_CAPTURE));
      for (int k = 1; k < 256; k++) tick(8'(3 * k));
      chk("coll_ready", 32'(bus.frame_ready), 32'd1);
      read_chk("coll_rd0", 8'd0, 8'd120);
      read_chk("coll_rd1", 8'd1, 8'd3);
      read_chk("coll_rd9", 8'd9, 8'd27);

      // auto mode forces a trigger on the 256th tick
      bus.trig_slope = 1'b0;
      bus.auto_mode  = 1'b1;
      pulse_rearm();
      for (int k = 0; k < 255; k++) tick(8'd50);
      chk("auto_pre_state", 32'(bus.state_dbg), 32'(S_ARMED));
      tick(8'd50);
      chk("auto_trig", 32'(bus.state_dbg), 32'(S_CAPTURE));
      for (int k = 0; k < 254; k++) tick(8'd50);
      chk("auto_not_ready", 32'(bus.frame_ready), 32'd0);
      tick(8'd50);
      chk("auto_ready", 32'(bus.frame_ready), 32'd1);
      read_chk("auto_rd0", 8'd0, 8'd50);
      read_chk("auto_rd128", 8'd128, 8'd50);
      read_chk("auto_rd255", 8'd255, 8'd50);

      // no auto trigger with auto_mode low
      bus.auto_mode = 1'b0;
      pulse_rearm();
      for (int k = 0; k < 1000; k++) tick(8'd50);
      chk("noauto_ready", 32'(bus.frame_ready), 32'd0);
      chk("noauto_busy", 32'(bus.busy), 32'd1);
      chk("noauto_state", 32'(bus.state_dbg), 32'(S_ARMED));

      // asynchronous reset mid-capture
      pulse_rearm();
      tick(8'd100);
      tick(8'd130);
      for (int k = 0; k < 99; k++) tick(8'd1);
      @(negedge clk);
      bus.rd_addr = 8'd0;
      @(negedge clk);
      chk("ares_pre_rd", 32'(bus.rd_data), 32'd130);
      chk("ares_pre_busy", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ares_rd_data", 32'(bus.rd_data), 32'd0);
      chk("ares_busy", 32'(bus.busy), 32'd0);
      chk("ares_ready", 32'(bus.frame_ready), 32'd0);
      chk("ares_state", 32'(bus.state_dbg), 32'(S_IDLE));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ares_rel_idle", 32'(bus.state_dbg), 32'(S_IDLE));
      @(negedge clk);
      chk("ares_rel_armed", 32'(bus.state_dbg), 32'(S_ARMED));
      chk("ares_rel_ready", 32'(bus.frame_ready), 32'd0);

      // report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
- Consumer of the divided sample clock produced by the time-division generator.
- Runs on sys_clk and detects each rising edge of the divided clock as a sample strobe.
- Waits for a level/slope trigger on the ADC stream, then captures one frame of DEPTH samples into an internal buffer.
- Holds the frame for the display reader until re-armed.

Parameters:
- DATA_W, 8, ADC sample width.
- ADDR_W, 8, frame buffer address width.
- DEPTH, 256, samples per frame; must equal 2**ADDR_W.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous reset, active low.
- sample_clk  in  1  divided clock from the time-division generator (sys_clk-synchronous level); its rising edge is the sample strobe.
- adc_data  in  DATA_W  current ADC sample, unsigned.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_slope  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- auto_mode  in  1  1 = force a trigger when none occurs within DEPTH strobes.
- rearm  in  1  single-cycle pulse: discard current frame or capture and re-arm.
- rd_addr  in  ADDR_W  display read address.
- rd_data  out  DATA_W  buffer word, registered.
- frame_ready  out  1  complete frame held in buffer.
- busy  out  1  armed or capturing.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; rd_data = 0; frame_ready = 0; busy = 0.
  - sample_clk_d = 0; prev_valid = 0; auto counter = 0; wr_addr = 0.
  - Buffer contents are not reset.
- Strobe: tick = sample_clk & ~sample_clk_d, where sample_clk_d is sample_clk registered every cycle. tick is combinational and lasts one sys_clk cycle per rising edge.
- On every tick in ARMED: prev <= adc_data; prev_valid <= 1.
- Trigger condition (unsigned compare), evaluated only on a tick with prev_valid = 1:
  - Rising: prev < trig_level && adc_data >= trig_level.
  - Falling: prev > trig_level && adc_data <= trig_level.
- The first tick after entering ARMED only loads prev and never triggers.
- States:
  - IDLE: go to ARMED unconditionally one cycle after reset release. Ticks are ignored.
  - ARMED (busy = 1):
    - Each tick increments the auto counter.
    - Trigger on a tick, or auto_mode = 1 and the DEPTH-th tick since arming (counter == DEPTH-1): write adc_data to mem[0], wr_addr <= 1, go to CAPTURE.
    - With auto_mode = 0 the counter saturates at DEPTH-1 and never forces a trigger.
  - CAPTURE (busy = 1):
    - Each tick writes adc_data to mem[wr_addr] and increments wr_addr.
    - The tick that writes address DEPTH-1 moves to HOLD.
  - HOLD: frame_ready = 1, busy = 0, no buffer writes, ticks ignored.
- rearm, any state except IDLE:
  - Next state = ARMED; frame_ready <= 0; prev_valid <= 0; auto counter <= 0; wr_addr <= 0.
  - rearm in ARMED or CAPTURE aborts and restarts arming. A partial frame is never flagged.
- Simultaneous rearm and tick: rearm wins. The tick is discarded, including the prev load.
- frame_ready and busy are registered and change on the same edge as the state register.
  - frame_ready rises on the edge after the final write.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, in any state: one-cycle latency.
  - Data is meaningful only while frame_ready = 1.
  - Write and read of the same address in one cycle returns old data. This is irrelevant in HOLD because no writes occur.
- Buffer: single-write, single-read synchronous RAM, inferable as block RAM. No write-first bypass.

Test Plan:
- Reset and arm: hold rst_n low for 5 cycles, toggling sample_clk -> rd_data = 0, frame_ready = 0, busy = 0. Release -> busy = 1 exactly one cycle later.
- Rising trigger: trig_level = 128, trig_slope = 0, adc ramp 100, 110, ... step 10 per tick -> trigger on 130. After 256 ticks total from trigger, frame_ready = 1. rd_addr = 0 gives rd_data = 130 one cycle later; rd_addr = 1 gives 140.
- First-tick suppression and falling slope: adc 200 on the first tick after arm (no trigger). Then 140 then 100 with trig_level = 128, trig_slope = 1 -> mem[0] = 100.
- Auto mode: adc constant 50, trig_level = 128.
  - auto_mode = 1 -> forced trigger on the 256th tick; frame_ready after tick 511; all reads = 50.
  - auto_mode = 0 -> frame_ready stays 0 after 1000 ticks.
- rearm abort and collision:
  - rearm at capture tick 10 -> busy stays 1, frame_ready = 0, the next frame starts fresh at mem[0].
  - rearm in the same cycle as a tick -> that sample is neither stored nor loaded into prev.
- Async reset mid-capture: assert rst_n at capture tick 100 -> outputs clear immediately without waiting for a clock edge. After release -> IDLE then ARMED, frame_ready = 0.
